// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus bridge: FSM encoding, default
// address map and well-known channel indices.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } busState_e;

   localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FF00;
   localparam int          DEF_WIN_LOG2  = 4;
   localparam int          DEF_TIMEOUT   = 15;
   localparam int          TIMER_W       = 8;

   localparam int CH_LED = 0;
   localparam int CH_SW  = 1;
   localparam int CH_SEG = 2;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational I/O window decoder: maps a byte address to a one-hot channel
// select and the offset inside that channel's window.
module periph_addr_decode
   import periph_bus_pkg::*;
#(
   parameter int              N_CH      = 4,
   parameter int              AW        = 32,
   parameter int              WIN_LOG2  = DEF_WIN_LOG2,
   parameter logic [AW-1:0]   BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic [AW-1:0]       addr,
   output logic                hit,
   output logic [N_CH-1:0]     chSel,
   output logic [WIN_LOG2-1:0] offset
);

   localparam logic [AW:0] SPAN = (AW+1)'(N_CH) << WIN_LOG2;

   logic [AW-1:0] rel;
   logic [AW-1:0] chIdx;

   // Full-width compare on both ends so nothing outside the region aliases in.
   // NOTE: every output of a combinational block gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      rel    = addr - BASE_ADDR;
      chIdx  = rel >> WIN_LOG2;
      hit    = (addr >= BASE_ADDR) && ({1'b0, rel} < SPAN);
      offset = rel[WIN_LOG2-1:0];
      chSel  = '0;
      for (int i = 0; i < N_CH; i++) begin
         chSel[i] = hit && (chIdx == AW'(i));
      end
   end

endmodule

// File: rtl/periph_bus_bridge.sv
// Memory-mapped I/O bridge: decodes core requests into channel windows, runs a
// select/ack handshake with wait states and timeout, returns a one-cycle response.
module periph_bus_bridge
   import periph_bus_pkg::*;
#(
   parameter int            N_CH      = 4,
   parameter int            DW        = 32,
   parameter int            AW        = 32,
   parameter logic [AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int            WIN_LOG2  = DEF_WIN_LOG2,
   parameter int            TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 IO_Valid,
   input  logic                 IO_WE,
   input  logic [AW-1:0]        IO_Addr,
   input  logic [DW-1:0]        IO_WriteData,
   output logic                 IO_Busy,
   output logic                 IO_Ready,
   output logic [DW-1:0]        IO_ReadData,
   output logic                 IO_Err,
   output logic [7:0]           ErrCount,
   output logic [N_CH-1:0]      P_Sel,
   output logic                 P_WE,
   output logic [WIN_LOG2-1:0]  P_Addr,
   output logic [DW-1:0]        P_WD,
   input  logic [N_CH*DW-1:0]   P_RD,
   input  logic [N_CH-1:0]      P_Ack
);

   busState_e state, stateNext;

   logic                decHit;
   logic [N_CH-1:0]     decSel;
   logic [WIN_LOG2-1:0] decOff;

   logic                weR;
   logic [N_CH-1:0]     selR;
   logic [WIN_LOG2-1:0] offR;
   logic [DW-1:0]       wdR;
   logic [TIMER_W-1:0]  timer;
   logic                errR;
   logic [DW-1:0]       rdR;
   logic [7:0]          errCnt;

   logic                goResp;
   logic                respErr;
   logic [DW-1:0]       respData;
   logic [DW-1:0]       rdMux;

   periph_addr_decode #(
      .N_CH      (N_CH),
      .AW        (AW),
      .WIN_LOG2  (WIN_LOG2),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .addr   (IO_Addr),
      .hit    (decHit),
      .chSel  (decSel),
      .offset (decOff)
   );

   always_comb begin
      rdMux = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (selR[i]) rdMux = rdMux | P_RD[i*DW +: DW];
      end
   end

   // Ack is tested before timeout so a late ack on the last cycle still succeeds.
   always_comb begin
      stateNext = state;
      goResp    = 1'b0;
      respErr   = 1'b0;
      respData  = '0;
      case (state)
         S_IDLE: begin
            if (IO_Valid) begin
               if (decHit) begin
                  stateNext = S_ACCESS;
               end else begin
                  stateNext = S_RESP;
                  goResp    = 1'b1;
                  respErr   = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (|(P_Ack & selR)) begin
               stateNext = S_RESP;
               goResp    = 1'b1;
               respData  = weR ? '0 : rdMux;
            end else if (timer == TIMER_W'(TIMEOUT)) begin
               stateNext = S_RESP;
               goResp    = 1'b1;
               respErr   = 1'b1;
            end
         end
         S_RESP:  stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         weR    <= 1'b0;
         selR   <= '0;
         offR   <= '0;
         wdR    <= '0;
         timer  <= '0;
         errR   <= 1'b0;
         rdR    <= '0;
         errCnt <= '0;
      end else begin
         if (state == S_IDLE && IO_Valid) begin
            weR  <= IO_WE;
            selR <= decSel;
            offR <= decOff;
            wdR  <= IO_WriteData;
         end
         timer <= (state == S_ACCESS && stateNext == S_ACCESS) ? timer + 1'b1 : '0;
         // Response registers live exactly for the single RESP cycle.
         errR  <= goResp ? respErr : 1'b0;
         rdR   <= goResp ? respData : '0;
         if (goResp && respErr && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
      end
   end

   assign IO_Busy     = (state != S_IDLE);
   assign IO_Ready    = (state == S_RESP);
   assign IO_Err      = errR;
   assign IO_ReadData = rdR;
   assign ErrCount    = errCnt;
   assign P_Sel       = (state == S_ACCESS) ? selR : '0;
   assign P_WE        = weR & (state == S_ACCESS);
   assign P_Addr      = offR;
   assign P_WD        = wdR;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed bench for periph_bus_bridge: peripheral ack models with
// programmable wait states and a scoreboard of expected responses.
module tb_periph_bus_bridge;
   import periph_bus_pkg::*;

   localparam int          N_CH = 4;
   localparam int          DW   = 32;
   localparam int          AW   = 32;
   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam int          MAX_WAIT = 40;

   logic                CLK;
   logic                Reset;
   logic                IO_Valid;
   logic                IO_WE;
   logic [AW-1:0]       IO_Addr;
   logic [DW-1:0]       IO_WriteData;
   logic                IO_Busy;
   logic                IO_Ready;
   logic [DW-1:0]       IO_ReadData;
   logic                IO_Err;
   logic [7:0]          ErrCount;
   logic [N_CH-1:0]     P_Sel;
   logic                P_WE;
   logic [3:0]          P_Addr;
   logic [DW-1:0]       P_WD;
   logic [N_CH*DW-1:0]  P_RD;
   logic [N_CH-1:0]     P_Ack;

   typedef struct {
      logic          err;
      logic [DW-1:0] rd;
      int            lat;
   } expT;

   expT  sb[$];
   int   nCmp = 0;
   int   nMis = 0;
   logic [7:0] errCntExp = 8'd0;

   int   ackDelay [N_CH];   // -1 = never acks
   int   waitCnt  [N_CH];
   logic strayAck3;

   periph_bus_bridge #(
      .N_CH (N_CH), .DW (DW), .AW (AW), .BASE_ADDR (BASE), .WIN_LOG2 (4), .TIMEOUT (15)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .IO_Valid     (IO_Valid),
      .IO_WE        (IO_WE),
      .IO_Addr      (IO_Addr),
      .IO_WriteData (IO_WriteData),
      .IO_Busy      (IO_Busy),
      .IO_Ready     (IO_Ready),
      .IO_ReadData  (IO_ReadData),
      .IO_Err       (IO_Err),
      .ErrCount     (ErrCount),
      .P_Sel        (P_Sel),
      .P_WE         (P_WE),
      .P_Addr       (P_Addr),
      .P_WD         (P_WD),
      .P_RD         (P_RD),
      .P_Ack        (P_Ack)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Peripheral models: ack after ackDelay[i] cycles of continuous selection.
   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < N_CH; i++) waitCnt[i] <= 0;
      end else begin
         for (int i = 0; i < N_CH; i++) waitCnt[i] <= P_Sel[i] ? waitCnt[i] + 1 : 0;
      end
   end

   always_comb begin
      P_Ack = '0;
      for (int i = 0; i < N_CH; i++) begin
         P_Ack[i] = P_Sel[i] && (ackDelay[i] >= 0) && (waitCnt[i] == ackDelay[i]);
      end
      P_Ack[3] = P_Ack[3] | strayAck3;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request at the current negedge (cycle 0) and follows it to IDLE.
   task automatic doAccess(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic expErr, input logic [DW-1:0] expRd, input int expLat,
                           input logic [N_CH-1:0] expSel, input bit holdValid, input string tag);
      expT e;
      int  lat;
      e.err = expErr;
      e.rd  = expRd;
      e.lat = expLat;
      sb.push_back(e);
      if (expErr && errCntExp != 8'hFF) errCntExp++;

      IO_Valid = 1'b1;  IO_WE = we;  IO_Addr = addr;  IO_WriteData = wd;
      @(negedge CLK);
      lat = 1;
      IO_Valid = 1'b0;
      check({tag, ".sel"}, 64'(P_Sel), 64'(expSel));
      if (expSel != '0) begin
         check({tag, ".pwe"},  64'(P_WE), 64'(we));
         check({tag, ".pwd"},  64'(P_WD), 64'(wd));
         check({tag, ".padr"}, 64'(P_Addr), 64'(addr[3:0]));
      end
      if (holdValid) begin
         IO_Valid = 1'b1;
         IO_Addr  = 32'h0000_1000;
      end
      while (!IO_Ready && lat < MAX_WAIT) begin
         @(negedge CLK);
         lat++;
      end
      IO_Valid = 1'b0;

      e = sb.pop_front();
      check({tag, ".lat"},   64'(lat), 64'(e.lat));
      check({tag, ".rdy"},   64'(IO_Ready), 64'd1);
      check({tag, ".err"},   64'(IO_Err), 64'(e.err));
      check({tag, ".rdata"}, 64'(IO_ReadData), 64'(e.rd));
      check({tag, ".busy"},  64'(IO_Busy), 64'd1);
      check({tag, ".selR"},  64'(P_Sel), 64'd0);

      @(negedge CLK);
      check({tag, ".rdy0"},  64'(IO_Ready), 64'd0);
      check({tag, ".busy0"}, 64'(IO_Busy), 64'd0);
      check({tag, ".err0"},  64'(IO_Err), 64'd0);
      check({tag, ".rd0"},   64'(IO_ReadData), 64'd0);
      check({tag, ".ecnt"},  64'(ErrCount), 64'(errCntExp));
   endtask

   logic [AW-1:0] badAddr [4];

   initial begin
      Reset = 1'b0;  IO_Valid = 1'b0;  IO_WE = 1'b0;  IO_Addr = '0;  IO_WriteData = '0;
      strayAck3 = 1'b0;
      ackDelay[CH_LED] = 0;  ackDelay[CH_SW] = 3;  ackDelay[CH_SEG] = -1;  ackDelay[3] = 0;
      P_RD = {32'h3333_3333, 32'h2222_2222, 32'h0000_A5A5, 32'hDEAD_0000};
      badAddr[0] = 32'h0000_1000;  badAddr[1] = BASE + 32'h40;
      badAddr[2] = BASE - 32'h1;   badAddr[3] = 32'h0000_0000;

      #2;
      check("rst.busy",  64'(IO_Busy), 64'd0);
      check("rst.ready", 64'(IO_Ready), 64'd0);
      check("rst.sel",   64'(P_Sel), 64'd0);
      check("rst.ecnt",  64'(ErrCount), 64'd0);
      check("rst.pwd",   64'(P_WD), 64'd0);
      repeat (3) @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);

      // 1: immediate write to LED; 2: SW read with three wait states, with a
      // request held during busy that must be ignored
      doAccess(1'b1, BASE + 32'h00, 32'h1234, 1'b0, 32'h0, 2, 4'b0001, 1'b0, "t1_wr_led");
      doAccess(1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'hA5A5, 5, 4'b0010, 1'b1, "t2_rd_sw");
      // 3: unmapped; 4: timeout on SEG
      doAccess(1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 1'b0, "t3_unmap");
      doAccess(1'b0, BASE + 32'h20, 32'h0, 1'b1, 32'h0, 17, 4'b0100, 1'b0, "t4_tmo");
      // Window edges: last byte of ch3 is mapped, the next byte is not.
      doAccess(1'b0, BASE + 32'h3F, 32'h0, 1'b0, 32'h3333_3333, 2, 4'b1000, 1'b0, "edge_hi");
      doAccess(1'b0, BASE + 32'h40, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 1'b0, "edge_out");
      doAccess(1'b1, BASE + 32'h1C, 32'hCAFE, 1'b0, 32'h0, 5, 4'b0010, 1'b0, "wr_sw");

      // 5: asynchronous reset in the middle of an access
      IO_Valid = 1'b1;  IO_WE = 1'b0;  IO_Addr = BASE + 32'h24;
      @(negedge CLK);
      IO_Valid = 1'b0;
      repeat (3) @(negedge CLK);
      check("t5.selpre", 64'(P_Sel), 64'b0100);
      #2 Reset = 1'b0;
      #1;
      check("t5.sel",   64'(P_Sel), 64'd0);
      check("t5.busy",  64'(IO_Busy), 64'd0);
      check("t5.ecnt",  64'(ErrCount), 64'd0);
      check("t5.ready", 64'(IO_Ready), 64'd0);
      check("t5.pwd",   64'(P_WD), 64'd0);
      errCntExp = 8'd0;
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      doAccess(1'b0, BASE + 32'h04, 32'h0, 1'b0, 32'hDEAD_0000, 2, 4'b0001, 1'b0, "t5_after");

      // 6: error counter saturation
      for (int i = 0; i < 254; i++) begin
         doAccess(1'b0, badAddr[i % 4], 32'h0, 1'b1, 32'h0, 1, 4'b0000, 1'b0, "t6_sat");
      end
      check("t6.ecnt254", 64'(ErrCount), 64'hFE);
      for (int i = 0; i < 46; i++) begin
         doAccess(1'b1, badAddr[i % 4], 32'h55, 1'b1, 32'h0, 1, 4'b0000, 1'b0, "t6_sat");
      end
      check("t6.ecntsat", 64'(ErrCount), 64'hFF);

      // Stray ack on an unselected channel must not end a slow ch0 access.
      ackDelay[CH_LED] = 3;
      strayAck3 = 1'b1;
      doAccess(1'b0, BASE + 32'h08, 32'h0, 1'b0, 32'hDEAD_0000, 5, 4'b0001, 1'b0, "t6_stray");
      strayAck3 = 1'b0;

      check("sb.empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
      $finish;
   end

endmodule
